// File: rtl/fetch_unit_if.sv
// Bus bundle for the fetch stage: instruction-memory port, decode-side output
// stream and the redirect input from branch/jump resolution.
interface fetch_unit_if;
    // Handshakes: imem_req is always accepted, and imem_rvalid follows exactly
    // one cycle later. The out stream transfers an entry in any cycle where
    // out_valid && out_ready are both high. out_valid does not depend on out_ready.
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc,
        input  imem_rvalid, imem_rdata, out_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc,
        output imem_rvalid, imem_rdata, out_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one-cycle-latency memory requests and
// buffers {pc, instr} pairs in a prefetch FIFO for decode; redirect flushes all.
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 2;

    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic          inflight;
    logic [AW:0]   count;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [31:0]   fifo_pc    [DEPTH];
    logic [31:0]   fifo_instr [DEPTH];

    logic          req;
    logic          push;
    logic          pop;
    logic [CW-1:0] occupancy;

    // Slots already spoken for, after this cycle's pop frees one. Letting the
    // pop feed straight into the credit check is what keeps 1 instr/cycle.
    always_comb begin
        pop       = (count != '0) && bus.out_ready;
        occupancy = CW'(count) + CW'(inflight) - CW'(pop);
        push      = bus.imem_rvalid && inflight && !bus.redirect_valid;
        req       = !rst && !bus.redirect_valid && (occupancy < CW'(DEPTH));
    end

    assign bus.imem_req  = req;
    assign bus.imem_addr = fetch_pc;
    assign bus.out_valid = (count != '0);
    assign bus.out_pc    = fifo_pc[rd_ptr];
    assign bus.out_instr = fifo_instr[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc <= bus.redirect_pc & ~32'h0000_0003;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (req) begin
                fetch_pc <= fetch_pc + 32'd4;
                req_pc   <= fetch_pc;
            end
            inflight <= req;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + (AW+1)'(1);
            else if (!push && pop)
                count <= count - (AW+1)'(1);
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= req_pc;
            fifo_instr[wr_ptr] <= bus.imem_rdata;
        end
    end

    no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && (count == (AW+1)'(DEPTH))));
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the RISC-V core. It owns the program counter, issues word-aligned requests to a 1-cycle-latency instruction memory, and buffers returned instructions with their PCs in a small FIFO. Instructions go to the decode/control stage over a valid/ready handshake. A redirect input from the branch/jump logic flushes everything fetched on the wrong path and restarts fetch at the target.

## Interface
- DEPTH, 4: prefetch FIFO entries (power of two, ≥2).
- RESET_PC, 32'h0000_0000: first fetch address after reset (word-aligned).

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  request valid this cycle (combinational).
- imem_addr  out  32  request address, always [1:0]=2'b00.
- imem_rvalid  in  1  response valid; the memory asserts it exactly 1 cycle after an accepted imem_req.
- imem_rdata  in  32  instruction word for the response.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  32  head instruction.
- out_pc  out  32  PC of the head instruction.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  32  new fetch address; bits [1:0] are ignored (forced to 0).

## Operation
- State: fetch_pc (32b), inflight (1b), FIFO of DEPTH × {pc, instr}, count (log2(DEPTH)+1 bits).
- The memory always accepts imem_req; there is no grant.
- Credit rule: imem_req = !redirect_valid && (count + inflight − pop < DEPTH), where pop = out_valid && out_ready. The combinational path from out_ready to imem_req is intentional and sustains 1 instr/cycle.
- imem_addr = fetch_pc. When imem_req is high: fetch_pc <= fetch_pc + 4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0), inflight <= 1, and the issued PC is captured for pairing with the response.
- Response: imem_rvalid && inflight && !redirect_valid → push {captured pc, imem_rdata}. imem_rvalid with inflight=0 is dropped silently.
- Pop: on pop, the head advances. Push and pop may occur in the same cycle; count is unchanged.
- FIFO output is registered: there is no bypass from imem_rdata to out_instr.
- Redirect, which has priority over everything:
  - count <= 0, read/write pointers reset, inflight <= 0.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - Any response in the same cycle is discarded.
  - No request is issued in the redirect cycle.
  - out_valid may be high in the redirect cycle. A pop in that cycle is still a legal handshake, but the entry is flushed regardless.
- The credit rule guarantees no overflow. A push when full is impossible by construction; an assertion is required in RTL.

## Timing
- During and after reset: fetch_pc=RESET_PC, count=0, inflight=0, out_valid=0. imem_req is held 0 while rst=1.
- First cycle after rst deasserts: imem_req=1, imem_addr=RESET_PC.
- Latency: request in cycle N → response in N+1 → out_valid with that entry in N+2.
- Redirect in cycle R: imem_req=0 in R, imem_req=1 at the target in R+1, first target instruction at out_valid in R+3.
- Steady state with out_ready=1: one instruction per cycle, with consecutive out_pc values differing by 4.
- Backpressure: with out_ready=0, requests stop once count + inflight = DEPTH. In-flight data is never lost.
- rst asserted mid-operation: all state clears immediately (asynchronously). The FIFO and the in-flight response are lost, and the first response cycle after reset is ignored because inflight=0.
- out_instr and out_pc are don't-care when out_valid=0. The bench must not check them.

## Test plan
- Reset release, RESET_PC=0, memory word k = 32'h0000_0013 + k, out_ready=1 → out_pc 0,4,8,… one per cycle, with the first out_valid 2 cycles after the first imem_req.
- out_ready=0 for 10 cycles from a stream start → exactly DEPTH=4 requests issued (addrs 0..12), then imem_req=0. Raise out_ready → PCs 0,4,8,12,16… in order, with no gaps or duplicates.
- Redirect to 32'h0000_0102 while the FIFO holds 3 entries and a response is in flight → out_valid=0 next cycle, imem_req=0 in the redirect cycle, next imem_addr=32'h0000_0100, and no stale PC ever appears on out_pc.
- Redirect asserted on two consecutive cycles (targets 0x40, then 0x80) → only the 0x80 stream appears, starting at out_pc=0x80.
- Redirect to 32'hFFFF_FFF8 with out_ready=1 → out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- rst pulsed asynchronously (mid-cycle) while the FIFO is full → out_valid and imem_req drop immediately. After release, fetch restarts at RESET_PC and the stray imem_rvalid in the first post-reset cycle is ignored.
